stochastic_addsub_frame: RTL and testbench
==========================================

Name: stochastic_addsub_frame

Overview:
- Multi-channel, frame-based sequential successor to the combinational MUX stochastic adder.
- Scales and combines N_CH unipolar/bipolar bitstreams using a per-cycle select. The select comes from an internal LFSR or an external port.
- Runs exactly LEN cycles per frame and counts output ones, so the frame result is read directly as count/LEN.
- Sits between the bitstream generators (SNGs) and the decode/compare logic in the stochastic arithmetic datapath.

Parameters:
- N_CH, 4, number of input channels; power of two, at least 2.
- LEN, 128, bitstream length (cycles) per frame; at least 2.
- LFSR_W, 8, internal LFSR width; must satisfy LFSR_W >= log2(N_CH).
- SEED, 8'hA5, LFSR load value at each frame start; nonzero.
- CNT_W, $clog2(LEN+1), width of the ones counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  frame start request; honoured only in IDLE
- mode  in  2  0=MUX scaled add, 1=bipolar scaled subtract, 2=OR saturating add, 3=MUX with external select
- ext_sel  in  log2(N_CH)  channel select, used in mode 3 only
- in_bits  in  N_CH  one bit per channel, sampled on each RUN cycle
- in_ready  out  1  high on every cycle in which in_bits is sampled (RUN)
- busy  out  1  high in RUN and DONE
- y  out  1  registered output bit
- y_valid  out  1  y is valid this cycle
- count  out  CNT_W  running/final ones count of y for the frame
- done  out  1  one-cycle pulse; count is final

Behaviour:
- Reset: state=IDLE. in_ready, busy, y, y_valid, done = 0; count = 0; beat counter = 0; LFSR = SEED. Reset in any state, including mid-RUN, aborts the frame and produces no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch mode into mode_q; clear count; beat=0; load LFSR=SEED; go to RUN.
  - mode changes after this latch have no effect until the next frame.
- RUN: in_ready=1.
  - Each cycle, compute y_comb from in_bits and sel.
  - sel = LFSR[log2(N_CH)-1:0] in modes 0–2; sel = ext_sel in mode 3.
  - LFSR advances one step per RUN cycle, after use.
  - beat increments each cycle. When beat == LEN-1, the state goes to DONE on the next edge.
  - RUN therefore lasts exactly LEN cycles: cycles k+1 through k+LEN.
- y_comb by mode_q:
  - 0: in_bits[sel].
  - 1: in_bits[sel] when sel is even; ~in_bits[sel] when sel is odd. With bipolar coding this gives mean(even channels) − mean(odd channels), scaled by 1/N_CH.
  - 2: OR of all in_bits.
  - 3: in_bits[ext_sel].
- Output stage latency is 1 cycle. On the edge after each RUN sample: y=y_comb, y_valid=1, count=count+y_comb.
  - y_valid is high on cycles k+2 through k+LEN+1; otherwise y_valid=0 and y holds its last value.
- DONE: one cycle only (k+LEN+1).
  - done=1, busy=1, in_ready=0.
  - y/y_valid show the final bit; count is final (0..LEN, no overflow by construction).
  - Next state is IDLE.
- count holds its final value in IDLE until the next accepted start clears it.
- start in RUN or DONE is ignored (it is not queued). start in the same cycle as rst: rst wins.
- LFSR: Fibonacci, taps given by LFSR_TAPS in the package. The default polynomial for width 8 is x^8+x^6+x^5+x^4+1. The update shifts left, with the feedback bit (XOR of the tapped bits) entering bit 0.
- The LFSR sequence is deterministic per frame (reloaded from SEED), so the bench can model it exactly.

Decomposition:
- Package stoch_pkg holds:
  - mode_e enum (MODE_ADD, MODE_SUB, MODE_OR, MODE_EXT);
  - state_e enum (IDLE, RUN, DONE);
  - LFSR_TAPS constant;
  - the default SEED constant.
- One sub-module, stoch_lfsr (params W, SEED, TAPS; ports clk, rst, load, en, q), reusable by the SNG blocks.

Test Plan:
- mode 3, ext_sel=0, in_bits=4'b0001 for the whole frame -> y_valid high for 128 cycles; count=128; done pulses exactly at cycle k+129.
- mode 2, in_bits=4'b0000 -> count=0. mode 2, in_bits=4'b0100 -> count=128.
- mode 0, in_bits=4'b1111 -> count=128. mode 0, in_bits=4'b0101 -> count equals the number of even LFSR selects over 128 steps from SEED=A5, matched against the bench model.
- mode 1, in_bits=4'b1111 -> y=1 only on even sel; count matches the model (≈64). in_bits=4'b1010 -> count=0.
- rst asserted for 1 cycle at RUN beat 50 -> busy=0, count=0, y_valid=0 next cycle; no done pulse. A new start then runs a full 128-beat frame.
- start held high through RUN and DONE -> exactly one frame per start accepted in IDLE. A start in IDLE on the cycle after DONE begins a new frame, with count cleared to 0.

Source files
------------

// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic arithmetic datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: operating modes, frame FSM states, default LFSR seed, the
// tap mask for the default 8-bit LFSR, and a tap lookup for other widths.
package stoch_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,   // MUX scaled add, LFSR select
        MODE_SUB = 2'd1,   // bipolar scaled subtract, LFSR select
        MODE_OR  = 2'd2,   // OR saturating add
        MODE_EXT = 2'd3    // MUX with external select
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    // x^8 + x^6 + x^5 + x^4 + 1 : tapped bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Tap masks for shift-left Fibonacci LFSRs. Bit (n-1) of the mask is
    // set for each x^n term of the feedback polynomial.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] m;
        case (w)
            2:       m = 32'h0000_0003;
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = {24'h0, LFSR_TAPS};
            16:      m = 32'h0000_B400;
            32:      m = 32'hA300_0000;
            // Non-maximal fallback: still never locks up from a nonzero seed.
            default: m = (32'h1 << (w - 1)) | (32'h1 << (w - 2));
        endcase
        return m;
    endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// Fibonacci LFSR, shift-left with feedback into bit 0; reloadable seed.
// Latency: q reflects load/advance one cycle after it is requested.
// Backpressure: none; en stalls the sequence, load has priority over en.
//
// Ports: clk, rst (sync, active-high, loads SEED), load (reload SEED),
//        en (advance one step), q (current state).
module stoch_lfsr #(
    parameter int           W    = 8,
    parameter logic [W-1:0] SEED = '1,
    parameter logic [W-1:0] TAPS = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (en) begin
            lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/stochastic_addsub_frame.sv
// Frame-based N_CH-channel stochastic add/sub/OR combiner with a ones counter.
// Latency: y is registered, 1 cycle after each in_bits sample; done at start+LEN+1.
// Backpressure: none; in_bits is consumed on every in_ready cycle, start ignored unless idle.
//
// Ports: clk, rst (sync, active-high); start, mode, ext_sel, in_bits (inputs);
//        in_ready (RUN), busy (RUN|DONE), y/y_valid (combined bit),
//        count (ones in y this frame), done (one-cycle, count final).
module stochastic_addsub_frame
    import stoch_pkg::*;
#(
    parameter int                N_CH   = 4,
    parameter int                LEN    = 128,
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [$clog2(N_CH)-1:0]       ext_sel,
    input  logic [N_CH-1:0]               in_bits,
    output logic                          in_ready,
    output logic                          busy,
    output logic                          y,
    output logic                          y_valid,
    output logic [$clog2(LEN+1)-1:0]      count,
    output logic                          done
);

    localparam int SEL_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(LEN + 1);

    localparam logic [31:0]       TAPS_FULL = lfsr_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS      = TAPS_FULL[LFSR_W-1:0];

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               y_q, y_d;
    logic               y_valid_q, y_valid_d;

    logic               lfsr_load;
    logic               lfsr_en;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [SEL_W-1:0]   sel;
    logic               y_comb;

    stoch_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .en   (lfsr_en),
        .q    (lfsr_q)
    );

    // Only the low SEL_W bits pick a channel; the rest just carry state.
    generate
        if (LFSR_W > SEL_W) begin : g_lfsr_hi
            logic lfsr_hi_unused;
            assign lfsr_hi_unused = ^lfsr_q[LFSR_W-1:SEL_W];
        end
    endgenerate

    assign sel = (mode_q == MODE_EXT) ? ext_sel : lfsr_q[SEL_W-1:0];

    // Odd channels are inverted in subtract mode: with bipolar coding ~x
    // represents -x, so the mux average becomes (sum even - sum odd)/N_CH.
    always_comb begin
        y_comb = 1'b0;
        case (mode_q)
            MODE_ADD: y_comb = in_bits[sel];
            MODE_SUB: y_comb = in_bits[sel] ^ sel[0];
            MODE_OR:  y_comb = |in_bits;
            MODE_EXT: y_comb = in_bits[ext_sel];
            default:  y_comb = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        beat_d    = beat_q;
        count_d   = count_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = mode_e'(mode);
                    count_d   = '0;
                    beat_d    = '0;
                    lfsr_load = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                lfsr_en   = 1'b1;
                y_d       = y_comb;
                y_valid_d = 1'b1;
                count_d   = count_q + CNT_W'(y_comb);
                beat_d    = beat_q + 1'b1;
                if (beat_q == CNT_W'(LEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE_ADD;
            beat_q    <= '0;
            count_q   <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            beat_q    <= beat_d;
            count_q   <= count_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign count    = count_q;

endmodule

// File: tb/tb_stochastic_addsub_frame.sv
module tb_stochastic_addsub_frame;

    localparam int LEN = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] ext_sel = 2'd0;
    logic [3:0] in_bits = 4'd0;
    logic       in_ready, busy, y, y_valid, done;
    logic [7:0] count;

    int vectors = 0;
    int miscompares = 0;

    // Per-frame observations
    int   r_inready, r_yv, r_yv_first, r_yv_last, r_done, r_done_at;
    int   r_done_count, r_idle_count, r_idle_busy;
    logic r_ys [0:LEN-1];

    // Reference model results
    logic exp_ys [0:LEN-1];
    int   exp_cnt;

    stochastic_addsub_frame dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .ext_sel  (ext_sel),
        .in_bits  (in_bits),
        .in_ready (in_ready),
        .busy     (busy),
        .y        (y),
        .y_valid  (y_valid),
        .count    (count),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Independent model: 8-bit LFSR, feedback = q7^q5^q4^q3, shifted in at bit 0.
    task automatic compute_exp(input logic [1:0] m, input logic [3:0] bits, input logic [1:0] es);
        logic [7:0] l;
        logic [1:0] s;
        l = 8'hA5;
        exp_cnt = 0;
        for (int j = 0; j < LEN; j++) begin
            s = (m == 2'd3) ? es : l[1:0];
            case (m)
                2'd0:    exp_ys[j] = bits[s];
                2'd1:    exp_ys[j] = s[0] ? ~bits[s] : bits[s];
                2'd2:    exp_ys[j] = |bits;
                default: exp_ys[j] = bits[s];
            endcase
            exp_cnt += int'(exp_ys[j]);
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endtask

    // Launch one frame and record what the DUT shows on each cycle k+n.
    task automatic run_frame(input logic [1:0] m, input logic [1:0] m_after,
                             input logic [1:0] es, input logic [3:0] bits);
        @(negedge clk);
        mode = m; ext_sel = es; in_bits = bits; start = 1'b1;
        r_inready = 0; r_yv = 0; r_yv_first = -1; r_yv_last = -1;
        r_done = 0; r_done_at = -1; r_done_count = -1;
        r_idle_count = -1; r_idle_busy = -1;
        for (int n = 1; n <= LEN + 2; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                mode  = m_after;
            end
            if (in_ready) r_inready++;
            if (y_valid) begin
                if (r_yv < LEN) r_ys[r_yv] = y;
                if (r_yv_first < 0) r_yv_first = n;
                r_yv_last = n;
                r_yv++;
            end
            if (done) begin
                r_done++;
                r_done_at = n;
                r_done_count = int'(count);
            end
            if (n == LEN + 2) begin
                r_idle_count = int'(count);
                r_idle_busy  = int'(busy);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; mode = 2'd3; in_bits = 4'hF;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        vectors++; if (y !== 1'b0) begin miscompares++; $display("FAIL rst_y: got %b want 0", y); end
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL rst_y_valid: got %b want 0", y_valid); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
        vectors++; if (count !== 8'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", count); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_wins_start: busy got %b want 0", busy); end
    endtask

    task automatic test_ext;
        // mode switched to ADD right after the latch; frame must stay in EXT
        run_frame(2'd3, 2'd0, 2'd0, 4'b0001);
        vectors++; if (r_yv !== LEN) begin miscompares++; $display("FAIL ext_yv_cycles: got %0d want %0d", r_yv, LEN); end
        vectors++; if (r_yv_first !== 2) begin miscompares++; $display("FAIL ext_yv_first: got %0d want 2", r_yv_first); end
        vectors++; if (r_yv_last !== LEN + 1) begin miscompares++; $display("FAIL ext_yv_last: got %0d want %0d", r_yv_last, LEN + 1); end
        vectors++; if (r_inready !== LEN) begin miscompares++; $display("FAIL ext_in_ready_cycles: got %0d want %0d", r_inready, LEN); end
        vectors++; if (r_done !== 1) begin miscompares++; $display("FAIL ext_done_pulses: got %0d want 1", r_done); end
        vectors++; if (r_done_at !== LEN + 1) begin miscompares++; $display("FAIL ext_done_cycle: got %0d want %0d", r_done_at, LEN + 1); end
        vectors++; if (r_done_count !== 128) begin miscompares++; $display("FAIL ext_count: got %0d want 128", r_done_count); end
        vectors++; if (r_idle_count !== 128) begin miscompares++; $display("FAIL ext_count_hold: got %0d want 128", r_idle_count); end
        vectors++; if (r_idle_busy !== 0) begin miscompares++; $display("FAIL ext_idle_busy: got %0d want 0", r_idle_busy); end
        // external select on channel 2 with only channel 1 set -> zero ones
        run_frame(2'd3, 2'd3, 2'd2, 4'b0010);
        vectors++; if (r_done_count !== 0) begin miscompares++; $display("FAIL ext_sel2_count: got %0d want 0", r_done_count); end
    endtask

    task automatic test_or;
        run_frame(2'd2, 2'd2, 2'd0, 4'b0000);
        vectors++; if (r_done_count !== 0) begin miscompares++; $display("FAIL or_0000_count: got %0d want 0", r_done_count); end
        run_frame(2'd2, 2'd2, 2'd0, 4'b0100);
        vectors++; if (r_done_count !== 128) begin miscompares++; $display("FAIL or_0100_count: got %0d want 128", r_done_count); end
    endtask

    task automatic test_add;
        int bad;
        run_frame(2'd0, 2'd0, 2'd0, 4'b1111);
        vectors++; if (r_done_count !== 128) begin miscompares++; $display("FAIL add_1111_count: got %0d want 128", r_done_count); end
        compute_exp(2'd0, 4'b0101, 2'd0);
        run_frame(2'd0, 2'd0, 2'd0, 4'b0101);
        vectors++; if (r_done_count !== exp_cnt) begin miscompares++; $display("FAIL add_0101_count: got %0d want %0d", r_done_count, exp_cnt); end
        bad = 0;
        for (int j = 0; j < LEN; j++) if (r_ys[j] !== exp_ys[j]) bad++;
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL add_0101_y_seq: got %0d wrong bits want 0", bad); end
    endtask

    task automatic test_sub;
        int bad;
        compute_exp(2'd1, 4'b1111, 2'd0);
        run_frame(2'd1, 2'd1, 2'd0, 4'b1111);
        vectors++; if (r_done_count !== exp_cnt) begin miscompares++; $display("FAIL sub_1111_count: got %0d want %0d", r_done_count, exp_cnt); end
        bad = 0;
        for (int j = 0; j < LEN; j++) if (r_ys[j] !== exp_ys[j]) bad++;
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL sub_1111_y_seq: got %0d wrong bits want 0", bad); end
        run_frame(2'd1, 2'd1, 2'd0, 4'b1010);
        vectors++; if (r_done_count !== 0) begin miscompares++; $display("FAIL sub_1010_count: got %0d want 0", r_done_count); end
    endtask

    task automatic test_reset_mid;
        int dn;
        @(negedge clk);
        mode = 2'd3; ext_sel = 2'd0; in_bits = 4'b0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);   // now in the RUN cycle with beat 50
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
        vectors++; if (count !== 8'd0) begin miscompares++; $display("FAIL mid_count: got %0d want 0", count); end
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL mid_y_valid: got %b want 0", y_valid); end
        dn = 0;
        for (int n = 0; n < LEN + 12; n++) begin
            if (done) dn++;
            @(negedge clk);
        end
        vectors++; if (dn !== 0) begin miscompares++; $display("FAIL mid_no_done: got %0d pulses want 0", dn); end
        run_frame(2'd3, 2'd3, 2'd0, 4'b0001);
        vectors++; if (r_done_at !== LEN + 1) begin miscompares++; $display("FAIL mid_restart_done_cycle: got %0d want %0d", r_done_at, LEN + 1); end
        vectors++; if (r_done_count !== 128) begin miscompares++; $display("FAIL mid_restart_count: got %0d want 128", r_done_count); end
    endtask

    task automatic test_back_to_back;
        int dn, first_at, second_at;
        @(negedge clk);
        mode = 2'd3; ext_sel = 2'd0; in_bits = 4'b0001; start = 1'b1;
        dn = 0; first_at = -1; second_at = -1;
        for (int n = 1; n <= 2 * LEN + 6; n++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (first_at < 0) first_at = n; else if (second_at < 0) second_at = n;
            end
            if (n == LEN + 2) begin
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
                vectors++; if (count !== 8'd128) begin miscompares++; $display("FAIL b2b_idle_count: got %0d want 128", count); end
            end
            if (n == LEN + 3) begin
                vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_restart_in_ready: got %b want 1", in_ready); end
                vectors++; if (count !== 8'd0) begin miscompares++; $display("FAIL b2b_count_cleared: got %0d want 0", count); end
            end
        end
        start = 1'b0;
        vectors++; if (dn !== 2) begin miscompares++; $display("FAIL b2b_done_pulses: got %0d want 2", dn); end
        vectors++; if (first_at !== LEN + 1) begin miscompares++; $display("FAIL b2b_first_done: got %0d want %0d", first_at, LEN + 1); end
        vectors++; if (second_at !== 2 * LEN + 3) begin miscompares++; $display("FAIL b2b_second_done: got %0d want %0d", second_at, 2 * LEN + 3); end
        // a third frame was accepted at the end; let it drain
        repeat (LEN + 4) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_drain_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_ext();
        test_or();
        test_add();
        test_sub();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
